tile_reader: RTL

TILE_READER -- requirements
Module: tile_reader

---
 rtl/tile_reader_pkg.sv | 26 ++
 rtl/tile_origin_lut.sv | 24 ++
 rtl/tile_reader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/tile_reader_pkg.sv
// rtl/tile_reader_pkg.sv - shared tile geometry, origin table and scan FSM states
package tile_reader_pkg;

    localparam int TILE_SIZE = 36;
    localparam int NUM_TILES = 9;

    // Row-major 3x3 board; entry i is the top-left corner of tile i.
    localparam logic [8:0][7:0] TILE_ORIGIN_X = {
        8'd100, 8'd62, 8'd24,
        8'd100, 8'd62, 8'd24,
        8'd100, 8'd62, 8'd24
    };
    localparam logic [8:0][6:0] TILE_ORIGIN_Y = {
        7'd80, 7'd80, 7'd80,
        7'd42, 7'd42, 7'd42,
        7'd4,  7'd4,  7'd4
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } tile_state_t;

endpackage

// File: rtl/tile_origin_lut.sv
// rtl/tile_origin_lut.sv - maps a tile index to its framebuffer origin
module tile_origin_lut
    import tile_reader_pkg::*;
(
    input  logic [3:0] location,
    output logic [7:0] origin_x,
    output logic [6:0] origin_y,
    output logic       valid
);

    always_comb begin
        origin_x = '0;
        origin_y = '0;
        valid    = 1'b0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (location == 4'(i)) begin
                origin_x = TILE_ORIGIN_X[i];
                origin_y = TILE_ORIGIN_Y[i];
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_reader.sv
// rtl/tile_reader.sv - scans one 36x36 tile and reports its colour and uniformity
module tile_reader
    import tile_reader_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [3:0]  location,
    input  logic [2:0]  rd_data,
    output logic [7:0]  rd_x,
    output logic [6:0]  rd_y,
    output logic        rd_en,
    output logic        busy,
    output logic        done,
    output logic [2:0]  tile_colour,
    output logic        uniform,
    output logic [10:0] mismatch_count,
    output logic        error
);

    localparam logic [5:0] LAST_OFS = 6'(TILE_SIZE - 1);

    tile_state_t state;
    logic [7:0]  org_x;
    logic [6:0]  org_y;
    logic [5:0]  ox;
    logic [5:0]  oy;
    logic        dv;
    logic        first_pix;

    logic [7:0]  lut_x;
    logic [6:0]  lut_y;
    logic        lut_valid;

    logic        pix_diff;
    logic [10:0] mm_next;

    tile_origin_lut u_origin_lut (
        .location (location),
        .origin_x (lut_x),
        .origin_y (lut_y),
        .valid    (lut_valid)
    );

    // Mismatch count including the pixel being captured this cycle, so DRAIN
    // can judge uniformity with the final pixel already accounted for.
    always_comb begin
        pix_diff = dv && !first_pix && (rd_data != tile_colour);
        mm_next  = mismatch_count + {10'd0, pix_diff};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            org_x          <= '0;
            org_y          <= '0;
            ox             <= '0;
            oy             <= '0;
            dv             <= 1'b0;
            first_pix      <= 1'b0;
            rd_en          <= 1'b0;
            rd_x           <= '0;
            rd_y           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            uniform        <= 1'b0;
            tile_colour    <= '0;
            mismatch_count <= '0;
        end else begin
            done <= 1'b0;
            dv   <= rd_en;

            if (dv) begin
                if (first_pix) begin
                    tile_colour <= rd_data;
                    first_pix   <= 1'b0;
                end else begin
                    mismatch_count <= mm_next;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy           <= 1'b1;
                        uniform        <= 1'b0;
                        mismatch_count <= '0;
                        tile_colour    <= '0;
                        if (lut_valid) begin
                            org_x     <= lut_x;
                            org_y     <= lut_y;
                            ox        <= '0;
                            oy        <= '0;
                            first_pix <= 1'b1;
                            error     <= 1'b0;
                            rd_en     <= 1'b1;
                            rd_x      <= lut_x;
                            rd_y      <= lut_y;
                            state     <= ST_READ;
                        end else begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_READ: begin
                    if (ox == LAST_OFS) begin
                        ox <= '0;
                        if (oy == LAST_OFS) begin
                            rd_en <= 1'b0;
                            state <= ST_DRAIN;
                        end else begin
                            oy   <= oy + 6'd1;
                            rd_x <= org_x;
                            rd_y <= org_y + 7'(oy) + 7'd1;
                        end
                    end else begin
                        ox   <= ox + 6'd1;
                        rd_x <= org_x + 8'(ox) + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    uniform <= (mm_next == '0);
                    done    <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
